// File: rtl/i2c_reg_slave.sv
// Write-only I2C target feeding single-cycle register-write strobes to the FIR register bank.
// SCL/SDA are oversampled by clk; ACK is driven through an open-drain enable on SDA.
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StData,
        StDataAck,
        StIgnore
    } state_t;

    state_t     state;
    logic       scl_meta, scl_sync, scl_prev;
    logic       sda_meta, sda_sync, sda_prev;
    logic [2:0] bit_cnt;
    logic       byte_full;
    logic [7:0] shreg;

    logic start_det, stop_det, scl_rise, scl_fall;

    // Two-stage synchronizers plus one history stage per line; idle bus level is high so
    // reset values produce no spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    // Line events decoded from the synchronized levels and their history.
    always_comb begin
        start_det = sda_prev & ~sda_sync & scl_sync;
        stop_det  = ~sda_prev & sda_sync & scl_sync;
        scl_rise  = ~scl_prev & scl_sync;
        scl_fall  = scl_prev & ~scl_sync;
    end

    // Protocol FSM with registered outputs; START/STOP take priority over SCL edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            shreg     <= 8'h00;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            // Auto-increment the pointer the clk after each write strobe (wraps naturally).
            if (reg_we) begin
                reg_addr <= reg_addr + 8'd1;
            end

            if (start_det) begin
                state     <= StAddr;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
            end else if (stop_det) begin
                state     <= StIdle;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    StAddr, StReg, StData: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_full <= 1'b1;
                            end
                        end else if (scl_fall && byte_full) begin
                            // Falls before the 8th bit (incl. the one right after START)
                            // are ignored.
                            byte_full <= 1'b0;
                            bit_cnt   <= 3'd0;
                            if (state == StAddr) begin
                                if (shreg[7:1] == SLAVE_ADDR && !shreg[0]) begin
                                    state  <= StAddrAck;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state  <= StIgnore;
                                    sda_oe <= 1'b0;
                                end
                            end else if (state == StReg) begin
                                reg_addr <= shreg;
                                state    <= StRegAck;
                                sda_oe   <= 1'b1;
                            end else begin
                                reg_wdata <= shreg;
                                reg_we    <= 1'b1;
                                state     <= StDataAck;
                                sda_oe    <= 1'b1;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= StReg;
                        end
                    end
                    StRegAck: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= StData;
                        end
                    end
                    StDataAck: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= StData;
                        end
                    end
                    StIgnore: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bit-banged I2C master bench for i2c_reg_slave: table-driven write transactions plus
// hand-written sequences for repeated START, aborted byte and mid-ACK reset.
module tb_i2c_reg_slave;

    localparam int Q = 8;  // clk per quarter SCL period (SCL = clk/32)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [15:0] strobes[$];
    logic        oe_seen = 1'b0;
    logic        we_long = 1'b0;
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_slave #(.SLAVE_ADDR(7'h2A)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .busy     (busy)
    );

    // Record write strobes, any SDA drive, and strobes longer than one clk.
    always @(negedge clk) begin
        if (reg_we) strobes.push_back({reg_addr, reg_wdata});
        if (sda_oe) oe_seen = 1'b1;
        if (reg_we && we_prev) we_long = 1'b1;
        we_prev = reg_we;
    end

    typedef struct {
        logic [4:0][7:0] b;
        int              n;
        logic [4:0]      ack_exp;  // expected SDA level in each ACK slot (0 = ACK)
        int              nwe;
        logic [2:0][7:0] ea;
        logic [2:0][7:0] ed;
        logic            oe_exp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            sda_m = b[i]; tick(Q);
            scl_m = 1'b1; tick(2 * Q);
            scl_m = 1'b0; tick(Q);
        end
    endtask

    task automatic get_ack(output logic a);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        a = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // START, n bytes each followed by an ACK check, STOP.
    task automatic xfer(input string tag, input logic [4:0][7:0] b, input int n,
                        input logic [4:0] ack_exp);
        logic a;
        send_start();
        for (int j = 0; j < n; j++) begin
            send_bits(b[j], 8);
            get_ack(a);
            check($sformatf("%s ack%0d", tag, j), {31'd0, a}, {31'd0, ack_exp[j]});
        end
        send_stop();
        tick(4);
    endtask

    task automatic check_one_strobe(input string tag, input logic [7:0] ea, input logic [7:0] ed);
        check({tag, " we_count"}, strobes.size(), 1);
        if (strobes.size() >= 1) check({tag, " strobe"}, {16'd0, strobes[0]}, {16'd0, ea, ed});
    endtask

    initial begin
        logic a;

        vecs[0].b = {8'h00, 8'h00, 8'hA5, 8'h10, 8'h54};
        vecs[0].n = 3; vecs[0].ack_exp = 5'b00000; vecs[0].nwe = 1;
        vecs[0].ea = {8'h00, 8'h00, 8'h10}; vecs[0].ed = {8'h00, 8'h00, 8'hA5}; vecs[0].oe_exp = 1;

        vecs[1].b = {8'h33, 8'h22, 8'h11, 8'hFE, 8'h54};
        vecs[1].n = 5; vecs[1].ack_exp = 5'b00000; vecs[1].nwe = 3;
        vecs[1].ea = {8'h00, 8'hFF, 8'hFE}; vecs[1].ed = {8'h33, 8'h22, 8'h11}; vecs[1].oe_exp = 1;

        vecs[2].b = {8'h00, 8'h00, 8'hA5, 8'h10, 8'h56};
        vecs[2].n = 3; vecs[2].ack_exp = 5'b00111; vecs[2].nwe = 0;
        vecs[2].ea = '0; vecs[2].ed = '0; vecs[2].oe_exp = 0;

        vecs[3].b = {8'h00, 8'h00, 8'h01, 8'h7F, 8'h54};
        vecs[3].n = 3; vecs[3].ack_exp = 5'b00000; vecs[3].nwe = 1;
        vecs[3].ea = {8'h00, 8'h00, 8'h7F}; vecs[3].ed = {8'h00, 8'h00, 8'h01}; vecs[3].oe_exp = 1;

        // Reset state
        tick(4);
        check("rst sda_oe", {31'd0, sda_oe}, 0);
        check("rst reg_we", {31'd0, reg_we}, 0);
        check("rst reg_addr", {24'd0, reg_addr}, 0);
        check("rst reg_wdata", {24'd0, reg_wdata}, 0);
        check("rst busy", {31'd0, busy}, 0);
        rst = 1'b0;
        tick(4);

        // Table-driven write transactions
        for (int v = 0; v < 4; v++) begin
            strobes.delete();
            oe_seen = 1'b0;
            xfer($sformatf("vec%0d", v), vecs[v].b, vecs[v].n, vecs[v].ack_exp);
            check($sformatf("vec%0d we_count", v), strobes.size(), vecs[v].nwe);
            for (int k = 0; k < vecs[v].nwe && k < strobes.size(); k++) begin
                check($sformatf("vec%0d strobe%0d", v, k), {16'd0, strobes[k]},
                      {16'd0, vecs[v].ea[k], vecs[v].ed[k]});
            end
            check($sformatf("vec%0d busy_after_stop", v), {31'd0, busy}, 0);
            check($sformatf("vec%0d sda_oe_after_stop", v), {31'd0, sda_oe}, 0);
            check($sformatf("vec%0d oe_seen", v), {31'd0, oe_seen}, {31'd0, vecs[v].oe_exp});
        end

        // Read request NACKed, then repeated START write
        strobes.delete();
        send_start();
        check("rd busy_after_start", {31'd0, busy}, 1);
        send_bits(8'h55, 8);
        get_ack(a);
        check("rd nack", {31'd0, a}, 1);
        check("rd no_we", strobes.size(), 0);
        xfer("rstart", {8'h00, 8'h00, 8'h5A, 8'h20, 8'h54}, 3, 5'b00000);
        check_one_strobe("rstart", 8'h20, 8'h5A);

        // STOP after 4 bits of a data byte
        strobes.delete();
        send_start();
        send_bits(8'h54, 8); get_ack(a);
        send_bits(8'h30, 8); get_ack(a);
        send_bits(8'hF0, 4);
        send_stop();
        tick(4);
        check("abort no_we", strobes.size(), 0);
        check("abort busy", {31'd0, busy}, 0);
        check("abort sda_oe", {31'd0, sda_oe}, 0);
        xfer("after_abort", {8'h00, 8'h00, 8'h77, 8'h31, 8'h54}, 3, 5'b00000);
        check_one_strobe("after_abort", 8'h31, 8'h77);

        // Reset asserted during the register-byte ACK
        strobes.delete();
        send_start();
        send_bits(8'h54, 8); get_ack(a);
        send_bits(8'h50, 8);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(2);
        check("mid_rst oe_before", {31'd0, sda_oe}, 1);
        rst = 1'b1;
        #1;
        check("mid_rst oe_async", {31'd0, sda_oe}, 0);
        check("mid_rst busy", {31'd0, busy}, 0);
        check("mid_rst reg_addr", {24'd0, reg_addr}, 0);
        tick(2);
        rst = 1'b0;
        tick(Q - 2);
        scl_m = 1'b0; tick(Q);
        send_bits(8'h99, 8); get_ack(a);
        check("mid_rst data_nack", {31'd0, a}, 1);
        send_bits(8'h88, 8); get_ack(a);
        send_stop();
        tick(4);
        check("mid_rst no_we", strobes.size(), 0);
        xfer("after_rst", {8'h00, 8'h00, 8'hC3, 8'h40, 8'h54}, 3, 5'b00000);
        check_one_strobe("after_rst", 8'h40, 8'hC3);

        check("we_single_cycle", {31'd0, we_long}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
